// File: rtl/matmul_tile_scheduler.sv
// Tile sequencer for the systolic-array matmul core. One host job covers an
// M x N grid of output tiles. The job is issued to the core one tile at a
// time, in row-major order with j innermost. Tile addresses are advanced by
// adders rather than recomputed with multipliers.
module matmul_tile_scheduler #(
  parameter int SYSTOLIC_ARRAY_DIM = 8,
  parameter int DATA_WIDTH_BITS    = 16
) (
  input  logic        clock,
  input  logic        areset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_m_tiles,
  input  logic [15:0] cmd_n_tiles,
  input  logic [19:0] cmd_inner_dimension,
  input  logic [63:0] cmd_act_base,
  input  logic [63:0] cmd_wgt_base,
  input  logic [63:0] cmd_out_base,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_tiles_done,
  output logic        core_cmd_valid,
  input  logic        core_cmd_ready,
  output logic [19:0] core_cmd_inner_dimension,
  output logic [63:0] core_cmd_act_addr,
  output logic [63:0] core_cmd_wgt_addr,
  output logic [63:0] core_cmd_out_addr,
  input  logic        core_resp_valid,
  output logic        core_resp_ready,
  output logic        busy
);

  localparam logic [63:0] ELEM_BYTES     = 64'(DATA_WIDTH_BITS / 8);
  localparam logic [63:0] ROW_BYTES      = 64'(SYSTOLIC_ARRAY_DIM) * ELEM_BYTES;
  localparam logic [63:0] OUT_TILE_BYTES = 64'(SYSTOLIC_ARRAY_DIM) * ROW_BYTES;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state;
  logic [15:0] m_tiles;
  logic [15:0] n_tiles;
  logic [15:0] i_idx;
  logic [15:0] j_idx;
  logic [63:0] wgt_base;
  logic [63:0] panel_stride;

  // Bytes spanned by one DIM-wide panel over the full inner dimension.
  // ROW_BYTES is a compile-time constant, so this is a constant scaling.
  function automatic logic [63:0] panel_stride_of(input logic [19:0] k);
    return 64'(k) * ROW_BYTES;
  endfunction

  // Job FSM: registered handshakes plus the running tile index/address state.
  always_ff @(posedge clock) begin
    if (areset) begin
      state                    <= IDLE;
      cmd_ready                <= 1'b1;
      resp_valid               <= 1'b0;
      core_cmd_valid           <= 1'b0;
      core_resp_ready          <= 1'b0;
      busy                     <= 1'b0;
      resp_tiles_done          <= '0;
      core_cmd_inner_dimension <= '0;
      core_cmd_act_addr        <= '0;
      core_cmd_wgt_addr        <= '0;
      core_cmd_out_addr        <= '0;
      m_tiles                  <= '0;
      n_tiles                  <= '0;
      i_idx                    <= '0;
      j_idx                    <= '0;
      wgt_base                 <= '0;
      panel_stride             <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            m_tiles                  <= cmd_m_tiles;
            n_tiles                  <= cmd_n_tiles;
            core_cmd_inner_dimension <= cmd_inner_dimension;
            core_cmd_act_addr        <= cmd_act_base;
            core_cmd_wgt_addr        <= cmd_wgt_base;
            core_cmd_out_addr        <= cmd_out_base;
            wgt_base                 <= cmd_wgt_base;
            panel_stride             <= panel_stride_of(cmd_inner_dimension);
            i_idx                    <= '0;
            j_idx                    <= '0;
            resp_tiles_done          <= '0;
            cmd_ready                <= 1'b0;
            busy                     <= 1'b1;
            // An empty grid or zero-length inner product has no tiles to run.
            if (cmd_m_tiles == 16'd0 || cmd_n_tiles == 16'd0 ||
                cmd_inner_dimension == 20'd0) begin
              state      <= DONE;
              resp_valid <= 1'b1;
            end else begin
              state          <= ISSUE;
              core_cmd_valid <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (core_cmd_ready) begin
            core_cmd_valid  <= 1'b0;
            core_resp_ready <= 1'b1;
            state           <= WAIT;
          end
        end
        WAIT: begin
          if (core_resp_valid) begin
            core_resp_ready   <= 1'b0;
            resp_tiles_done   <= resp_tiles_done + 32'd1;
            core_cmd_out_addr <= core_cmd_out_addr + OUT_TILE_BYTES;
            if (j_idx == n_tiles - 16'd1) begin
              j_idx             <= '0;
              core_cmd_wgt_addr <= wgt_base;
              core_cmd_act_addr <= core_cmd_act_addr + panel_stride;
              if (i_idx == m_tiles - 16'd1) begin
                state      <= DONE;
                resp_valid <= 1'b1;
              end else begin
                i_idx          <= i_idx + 16'd1;
                state          <= ISSUE;
                core_cmd_valid <= 1'b1;
              end
            end else begin
              j_idx             <= j_idx + 16'd1;
              core_cmd_wgt_addr <= core_cmd_wgt_addr + panel_stride;
              state             <= ISSUE;
              core_cmd_valid    <= 1'b1;
            end
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Directed bench for matmul_tile_scheduler: a table of jobs driven through a
// cycle-accurate handshake task, plus stall, back-pressure and reset sequences.
module tb_matmul_tile_scheduler;

  logic        clock = 1'b0;
  logic        areset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_m_tiles;
  logic [15:0] cmd_n_tiles;
  logic [19:0] cmd_inner_dimension;
  logic [63:0] cmd_act_base;
  logic [63:0] cmd_wgt_base;
  logic [63:0] cmd_out_base;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_tiles_done;
  logic        core_cmd_valid;
  logic        core_cmd_ready;
  logic [19:0] core_cmd_inner_dimension;
  logic [63:0] core_cmd_act_addr;
  logic [63:0] core_cmd_wgt_addr;
  logic [63:0] core_cmd_out_addr;
  logic        core_resp_valid;
  logic        core_resp_ready;
  logic        busy;

  always #5 clock = ~clock;

  matmul_tile_scheduler #(.SYSTOLIC_ARRAY_DIM(8), .DATA_WIDTH_BITS(16)) dut (
    .clock                   (clock),
    .areset                  (areset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_m_tiles             (cmd_m_tiles),
    .cmd_n_tiles             (cmd_n_tiles),
    .cmd_inner_dimension     (cmd_inner_dimension),
    .cmd_act_base            (cmd_act_base),
    .cmd_wgt_base            (cmd_wgt_base),
    .cmd_out_base            (cmd_out_base),
    .resp_valid              (resp_valid),
    .resp_ready              (resp_ready),
    .resp_tiles_done         (resp_tiles_done),
    .core_cmd_valid          (core_cmd_valid),
    .core_cmd_ready          (core_cmd_ready),
    .core_cmd_inner_dimension(core_cmd_inner_dimension),
    .core_cmd_act_addr       (core_cmd_act_addr),
    .core_cmd_wgt_addr       (core_cmd_wgt_addr),
    .core_cmd_out_addr       (core_cmd_out_addr),
    .core_resp_valid         (core_resp_valid),
    .core_resp_ready         (core_resp_ready),
    .busy                    (busy)
  );

  typedef struct {
    logic [15:0] m;
    logic [15:0] n;
    logic [19:0] k;
    logic [63:0] act;
    logic [63:0] wgt;
    logic [63:0] out;
    int          exp_tiles;
  } job_t;

  job_t        jobs [7];
  logic [63:0] hand_act [6];
  logic [63:0] hand_wgt [6];
  logic [63:0] hand_out [6];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b expected=%0b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk1({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_resp_valid"}, resp_valid, 1'b0);
    chk1({tag, "_core_cmd_valid"}, core_cmd_valid, 1'b0);
    chk1({tag, "_core_resp_ready"}, core_resp_ready, 1'b0);
  endtask

  // Runs one job from the table. cstall: cycles core_cmd_ready is held low
  // per tile; rdelay: cycles before core_resp_valid; hstall: cycles resp_ready
  // is held low; abort_tile >= 0 asserts reset in WAIT of that tile.
  task automatic run_job(input int idx, input int cstall, input int rdelay,
                         input int hstall, input int abort_tile);
    job_t        jb;
    logic [63:0] stride, ea, ew, eo;
    int          cyc;
    int          n_i;
    jb     = jobs[idx];
    stride = 64'(jb.k) * 64'd16;
    cmd_valid           = 1'b1;
    cmd_m_tiles         = jb.m;
    cmd_n_tiles         = jb.n;
    cmd_inner_dimension = jb.k;
    cmd_act_base        = jb.act;
    cmd_wgt_base        = jb.wgt;
    cmd_out_base        = jb.out;
    cyc = 0;
    while (!cmd_ready && cyc < 20) begin
      tick();
      cyc++;
    end
    chk1("cmd_ready_wait", cmd_ready, 1'b1);
    tick();
    // Command has fired; scramble the inputs so only latched values matter.
    cmd_valid           = 1'b0;
    cmd_m_tiles         = 16'($urandom_range(1, 9));
    cmd_n_tiles         = 16'($urandom_range(1, 9));
    cmd_inner_dimension = 20'($urandom_range(1, 999));
    cmd_act_base        = {32'($urandom), 32'($urandom)};
    cmd_wgt_base        = {32'($urandom), 32'($urandom)};
    cmd_out_base        = {32'($urandom), 32'($urandom)};
    chk1("busy_after_accept", busy, 1'b1);
    chk1("cmd_ready_after_accept", cmd_ready, 1'b0);
    if (jb.exp_tiles == 0) begin
      chk1("degen_resp_next_cycle", resp_valid, 1'b1);
      chk1("degen_no_core_cmd", core_cmd_valid, 1'b0);
    end
    for (int t = 0; t < jb.exp_tiles; t++) begin
      n_i = int'(jb.n);
      if (idx == 0) begin
        ea = hand_act[t];
        ew = hand_wgt[t];
        eo = hand_out[t];
      end else begin
        ea = jb.act + 64'(t / n_i) * stride;
        ew = jb.wgt + 64'(t % n_i) * stride;
        eo = jb.out + 64'(t) * 64'd128;
      end
      chk1("core_cmd_valid_rise", core_cmd_valid, 1'b1);
      for (int s = 0; s < cstall; s++) begin
        core_resp_valid = (s == 1);
        chk1("stall_core_cmd_valid", core_cmd_valid, 1'b1);
        chk1("stall_no_resp_ack", core_resp_ready, 1'b0);
        chk("stall_act", core_cmd_act_addr, ea);
        chk("stall_wgt", core_cmd_wgt_addr, ew);
        chk("stall_out", core_cmd_out_addr, eo);
        tick();
      end
      core_resp_valid = 1'b0;
      core_cmd_ready  = 1'b1;
      chk1("issue_valid", core_cmd_valid, 1'b1);
      chk("tile_act", core_cmd_act_addr, ea);
      chk("tile_wgt", core_cmd_wgt_addr, ew);
      chk("tile_out", core_cmd_out_addr, eo);
      chk("tile_k", 64'(core_cmd_inner_dimension), 64'(jb.k));
      tick();
      core_cmd_ready = 1'b0;
      chk1("one_outstanding", core_cmd_valid, 1'b0);
      chk1("wait_resp_ready", core_resp_ready, 1'b1);
      if (t == abort_tile) begin
        areset = 1'b1;
        tick();
        areset = 1'b0;
        chk_idle_outputs("abort");
        return;
      end
      for (int s = 0; s < rdelay; s++) begin
        chk1("wait_no_cmd", core_cmd_valid, 1'b0);
        chk1("wait_ready_held", core_resp_ready, 1'b1);
        tick();
      end
      core_resp_valid = 1'b1;
      tick();
      core_resp_valid = 1'b0;
    end
    chk1("done_resp_valid", resp_valid, 1'b1);
    chk("done_tiles", 64'(resp_tiles_done), 64'(jb.exp_tiles));
    for (int s = 0; s < hstall; s++) begin
      chk1("hold_resp_valid", resp_valid, 1'b1);
      chk("hold_tiles", 64'(resp_tiles_done), 64'(jb.exp_tiles));
      chk1("hold_cmd_ready", cmd_ready, 1'b0);
      chk1("hold_no_core_cmd", core_cmd_valid, 1'b0);
      tick();
    end
    // Offer a new command in the resp fire cycle; it must not be taken.
    resp_ready          = 1'b1;
    cmd_valid           = 1'b1;
    cmd_m_tiles         = 16'd1;
    cmd_n_tiles         = 16'd1;
    cmd_inner_dimension = 20'd1;
    tick();
    resp_ready = 1'b0;
    cmd_valid  = 1'b0;
    chk1("post_resp_valid_low", resp_valid, 1'b0);
    chk1("post_resp_cmd_ready", cmd_ready, 1'b1);
    chk1("post_resp_not_accepted", busy, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    jobs[0] = '{16'd2, 16'd3, 20'd32, 64'h1000, 64'h8000, 64'h20000, 6};
    jobs[1] = '{16'd0, 16'd4, 20'd16, 64'h100, 64'h200, 64'h300, 0};
    jobs[2] = '{16'd3, 16'd0, 20'd8, 64'h100, 64'h200, 64'h300, 0};
    jobs[3] = '{16'd1, 16'd1, 20'd0, 64'h100, 64'h200, 64'h300, 0};
    jobs[4] = '{16'd1, 16'd2, 20'd1, 64'h4000, 64'h5000, 64'h6000, 2};
    jobs[5] = '{16'd3, 16'd2, 20'd4, 64'hFFFF_FFFF_FFFF_FF80, 64'h10, 64'h7000_0000, 6};
    jobs[6] = '{16'd1, 16'd1, 20'd8, 64'hA000, 64'hB000, 64'hC000, 1};
    hand_act = '{64'h1000, 64'h1000, 64'h1000, 64'h1200, 64'h1200, 64'h1200};
    hand_wgt = '{64'h8000, 64'h8200, 64'h8400, 64'h8000, 64'h8200, 64'h8400};
    hand_out = '{64'h20000, 64'h20080, 64'h20100, 64'h20180, 64'h20200, 64'h20280};

    areset = 1'b1;
    cmd_valid = 1'b0;
    cmd_m_tiles = '0;
    cmd_n_tiles = '0;
    cmd_inner_dimension = '0;
    cmd_act_base = '0;
    cmd_wgt_base = '0;
    cmd_out_base = '0;
    resp_ready = 1'b0;
    core_cmd_ready = 1'b0;
    core_resp_valid = 1'b0;
    tick();
    tick();
    chk_idle_outputs("reset");
    chk("reset_tiles_done", 64'(resp_tiles_done), 64'd0);
    chk("reset_act", core_cmd_act_addr, 64'd0);
    chk("reset_out", core_cmd_out_addr, 64'd0);
    areset = 1'b0;
    tick();

    run_job(0, 0, 0, 0, -1);
    run_job(1, 0, 0, 2, -1);
    run_job(2, 0, 0, 0, -1);
    run_job(3, 0, 0, 0, -1);
    run_job(4, 1, 2, 0, -1);
    run_job(5, 0, 1, 1, -1);
    run_job(0, 5, 10, 0, -1);
    run_job(6, 0, 0, 4, -1);
    run_job(0, 0, 0, 0, 2);
    run_job(4, 0, 0, 0, -1);
    run_job(5, 2, 0, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_tile_scheduler.md
# matmul_tile_scheduler

Sequencer in front of the systolic-array matmul core. Accepts one large matrix multiply (M×N output expressed in DIM×DIM tiles, shared inner dimension K) and issues one core matmul command per output tile. Computes per-tile activation, weight and output addresses, waits for each core response before issuing the next tile, then returns a single completion response. Sits between the host command interface and the core's `cmd_matmul`/`resp_matmul` ports.

## Interface
- SYSTOLIC_ARRAY_DIM, 8, tile edge length in elements
- DATA_WIDTH_BITS, 16, element width; multiple of 8
- clock  in  1  clock; all logic on rising edge
- areset  in  1  reset, synchronous, active-high
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  host command ready
- cmd_m_tiles  in  16  output tile rows
- cmd_n_tiles  in  16  output tile columns
- cmd_inner_dimension  in  20  K, passed unchanged to the core
- cmd_act_base  in  64  activation base byte address
- cmd_wgt_base  in  64  weight base byte address
- cmd_out_base  in  64  output base byte address
- resp_valid  out  1  job complete
- resp_ready  in  1  host accepts completion
- resp_tiles_done  out  32  number of tiles issued for the job
- core_cmd_valid  out  1  tile command valid
- core_cmd_ready  in  1  core accepts tile command
- core_cmd_inner_dimension  out  20  K for the tile
- core_cmd_act_addr  out  64  tile activation address
- core_cmd_wgt_addr  out  64  tile weight address
- core_cmd_out_addr  out  64  tile output address
- core_resp_valid  in  1  core finished tile
- core_resp_ready  out  1  scheduler accepts tile completion
- busy  out  1  high in any state except IDLE

## Operation
- Let B = DATA_WIDTH_BITS/8, T = DIM·K·B (panel stride), O = DIM·DIM·B (output tile bytes). Both are computed in 64 bits, zero-extended, modulo 2^64.
- Tile (i,j) uses the following addresses: act = act_base + i·T, wgt = wgt_base + j·T, out = out_base + (i·n_tiles + j)·O.
- Order is row-major, with j innermost: (0,0),(0,1)…(0,N-1),(1,0)…
- Addresses are kept in registers and advanced by adders; no multipliers are used.
  - After each tile, out += O.
  - If j < N-1: j++, wgt += T.
  - Otherwise: j = 0, wgt = wgt_base, i++, act += T.
- The command fields (m_tiles, n_tiles, K, bases) are latched when the command fires. Changes on the input ports after that have no effect.
- States:
  - IDLE: cmd_ready = 1. When cmd fires, go to ISSUE. If m_tiles = 0, n_tiles = 0, or K = 0, go to DONE instead, with tiles_done = 0 and no core commands.
  - ISSUE: core_cmd_valid = 1. When core_cmd fires, go to WAIT.
  - WAIT: core_resp_ready = 1. When core_resp fires, tiles_done++ and advance the indices and addresses. If the tile just completed was (M-1,N-1), go to DONE; otherwise go to ISSUE.
  - DONE: resp_valid = 1. When resp fires, go to IDLE.
- Only one tile is ever outstanding.
- core_resp_valid outside WAIT is not acknowledged (ready = 0).
- resp_tiles_done is held stable throughout DONE and equals M·N for a non-degenerate job.

## Timing
- Reset values: state IDLE, cmd_ready = 1, all other outputs 0, busy = 0.
- Reset takes effect mid-job: the next cycle is IDLE with all valids low. The core is not notified; the system resets the core together with the scheduler.
- The core_cmd_* outputs come directly from registers. They are stable while core_cmd_valid = 1 and not ready.
- From cmd fire (cycle t), core_cmd_valid first rises at t+1.
- From core_resp fire (cycle t), the next core_cmd_valid rises at t+1. This is one idle cycle per tile boundary.
- After the last core_resp fire at cycle t, resp_valid rises at t+1.
- For a degenerate job fired at cycle t, resp_valid rises at t+1.
- When resp fires at t, cmd_ready is 1 at t+1. A new command is never accepted in the same cycle as resp.
- Valid/ready on every interface: a transfer occurs on a cycle where both are high. The valid side holds valid and data until the transfer.

## Test plan
- DIM=8, DW=16, M=2, N=3, K=32, act=0x1000, wgt=0x8000, out=0x20000 (T=512, O=128). Required: 6 core commands with (act, wgt, out) = (0x1000,0x8000,0x20000), (0x1000,0x8200,0x20080), (0x1000,0x8400,0x20100), (0x1200,0x8000,0x20180), (0x1200,0x8200,0x20200), (0x1200,0x8400,0x20280); then resp_tiles_done = 6.
- M=0, N=4, K=16 -> resp_valid one cycle after accept, tiles_done = 0, core_cmd_valid never asserted.
- core_cmd_ready held low 5 cycles, then core_resp delayed 10 cycles. Required: command fields stable while stalled; exactly one tile outstanding; core_resp_valid pulsed during ISSUE is not acknowledged.
- M=1, N=1 with resp_ready low 4 cycles. Required: resp_valid and tiles_done = 1 held; cmd_ready = 0 until the cycle after resp fires.
- Reset asserted in WAIT of tile 3 of a 2×3 job. Required: next cycle IDLE, busy = 0, all valids 0; a new 1×2 job then runs correctly from tile (0,0).
- Back-to-back jobs with changed inputs after accept. Required: the second job's addresses derive only from its own latched fields.
